// File: rtl/xadc_sample_ctrl.sv
// Periodic XADC temperature sampler: issues convst, reads the result over DRP once
// eoc arrives, and publishes the truncated average of every 2^AVG_LOG2 samples.
module xadc_sample_ctrl #(
   parameter logic [6:0] CHAN_ADDR = 7'h03,
   parameter int         AVG_LOG2  = 2,
   parameter int         PERIOD    = 1000,
   parameter int         TIMEOUT   = 255
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic        enable,
   input  logic        eoc,
   input  logic        drdy,
   input  logic [15:0] do_in,
   output logic        convst,
   output logic        den,
   output logic [6:0]  daddr,
   output logic [11:0] digitalTemp,
   output logic        ready,
   output logic        timeout_err
);

   localparam int ACC_W  = 12 + AVG_LOG2;
   localparam int CNT_W  = AVG_LOG2 + 1;
   localparam int WAIT_W = $clog2(TIMEOUT + 2);
   localparam int PER_W  = $clog2(PERIOD + 2);

   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(1 << AVG_LOG2);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
   localparam logic [PER_W-1:0]  PER_LAST = PER_W'(PERIOD - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT_EOC,
      READ,
      WAIT_DRDY,
      ACCUM,
      WAIT_PERIOD
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [WAIT_W-1:0]  wait_cnt;
   logic [PER_W-1:0]   per_cnt;
   logic [ACC_W-1:0]   acc;
   logic [CNT_W-1:0]   cnt;
   logic               wait_expired;
   logic               per_done;
   logic               unused_low_bits;

   assign daddr           = CHAN_ADDR;
   assign wait_expired    = (wait_cnt == WAIT_MAX);
   assign per_done        = (per_cnt >= PER_LAST);
   assign unused_low_bits = ^do_in[3:0];

   // NOTE: every output of this block gets a default before the case, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_nxt   = state;
      convst      = 1'b0;
      den         = 1'b0;
      timeout_err = 1'b0;
      case (state)
         IDLE:        if (enable) state_nxt = START;
         START: begin
            convst    = 1'b1;
            state_nxt = WAIT_EOC;
         end
         WAIT_EOC: begin
            if (eoc) begin
               state_nxt = READ;
            end else if (wait_expired) begin
               timeout_err = 1'b1;
               state_nxt   = WAIT_PERIOD;
            end
         end
         READ: begin
            den       = 1'b1;
            state_nxt = WAIT_DRDY;
         end
         WAIT_DRDY: begin
            if (drdy) begin
               state_nxt = ACCUM;
            end else if (wait_expired) begin
               timeout_err = 1'b1;
               state_nxt   = WAIT_PERIOD;
            end
         end
         ACCUM:       state_nxt = WAIT_PERIOD;
         WAIT_PERIOD: if (per_done) state_nxt = enable ? START : IDLE;
         default:     state_nxt = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         per_cnt     <= '0;
         acc         <= '0;
         cnt         <= '0;
         digitalTemp <= '0;
         ready       <= 1'b0;
      end else begin
         state <= state_nxt;

         if (state == START || state == READ)
            wait_cnt <= '0;
         else if ((state == WAIT_EOC || state == WAIT_DRDY) && !wait_expired)
            wait_cnt <= wait_cnt + WAIT_W'(1);

         // START counts as period cycle 0, so the register holds 1 on the next cycle.
         if (state == START)
            per_cnt <= PER_W'(1);
         else if (!per_done)
            per_cnt <= per_cnt + PER_W'(1);

         if (state == IDLE) begin
            acc <= '0;
            cnt <= '0;
         end else if (state == WAIT_DRDY && drdy) begin
            acc <= acc + ACC_W'(do_in[15:4]);
            cnt <= cnt + CNT_W'(1);
         end else if (state == ACCUM && cnt == CNT_FULL) begin
            digitalTemp <= acc[ACC_W-1 -: 12];
            ready       <= 1'b1;
            acc         <= '0;
            cnt         <= '0;
         end
      end
   end

endmodule
